// File: rtl/spi_slave_tx.sv
// SPI slave transmitter (MISO side), mode 3 (CPOL=1, CPHA=1), MSB first.
// A frame of NUM_BYTES bytes is captured on the first falling sclk edge
// of a transaction and shifted out one bit per falling edge. Once the
// frame is exhausted the fill byte is repeated and overrun is flagged.
// Raising ss clears all transaction state asynchronously, so every
// transaction starts again from byte 0, bit 7.
module spi_slave_tx #(
    parameter int          NUM_BYTES = 8,
    parameter logic [7:0]  FILL_BYTE = 8'hFF,
    localparam int         BC_W      = $clog2(NUM_BYTES) + 1
) (
    input  logic                     rst_n,
    input  logic                     sclk,
    input  logic                     ss,
    input  logic [NUM_BYTES*8-1:0]   tx_frame,
    input  logic                     tx_valid,
    output logic                     miso,
    output logic                     miso_oe,
    output logic [2:0]               bit_count,
    output logic [BC_W-1:0]          byte_count,
    output logic                     byte_sent,
    output logic                     frame_done,
    output logic                     underrun,
    output logic                     overrun,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        OVERFLOW = 2'd2
    } state_t;

    state_t                    state_r;
    logic [NUM_BYTES*8-1:0]    frame_r;
    logic                      miso_r;
    logic [2:0]                bit_count_r;
    logic [BC_W-1:0]           byte_count_r;
    logic                      byte_sent_r;
    logic                      frame_done_r;
    logic                      underrun_r;
    logic                      overrun_r;
    logic                      busy_r;

    logic [2:0]                nxt_bit_s;
    logic [BC_W-1:0]           nxt_byte_s;
    logic                      shift_bit_s;
    logic                      fill_bit_s;
    logic                      load_bit_s;
    logic [7:0]                load_byte_s;
    logic                      last_edge_s;

    // Selects bit i (0 = MSB) of byte b of a frame; loop keeps the byte
    // index width independent of the frame size.
    function automatic logic pick_bit(input logic [NUM_BYTES*8-1:0] f,
                                      input logic [BC_W-1:0]        b,
                                      input logic [2:0]             i);
        logic       r;
        logic [7:0] byte_v;
        r = 1'b0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            byte_v = f[8*k +: 8];
            if (b == BC_W'(k)) begin
                r = byte_v[~i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next bit/byte indices and the bit that each state would drive next.
    always_comb begin
        nxt_bit_s   = bit_count_r + 3'd1;
        nxt_byte_s  = byte_count_r;
        if (bit_count_r == 3'd7) begin
            nxt_byte_s = byte_count_r + BC_W'(1);
        end else begin
            nxt_byte_s = byte_count_r;
        end
        shift_bit_s = pick_bit(frame_r, nxt_byte_s, nxt_bit_s);
        fill_bit_s  = FILL_BYTE[~nxt_bit_s];
        load_byte_s = tx_valid ? tx_frame[7:0] : FILL_BYTE;
        load_bit_s  = load_byte_s[7];
        last_edge_s = (nxt_bit_s == 3'd7) && (nxt_byte_s == BC_W'(NUM_BYTES - 1));
    end

    // Transaction FSM and shift datapath; ss high or reset clears it all.
    always_ff @(negedge sclk or negedge rst_n or posedge ss) begin
        if (!rst_n || ss) begin
            state_r      <= IDLE;
            frame_r      <= '0;
            miso_r       <= 1'b0;
            bit_count_r  <= 3'd0;
            byte_count_r <= '0;
            byte_sent_r  <= 1'b0;
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    frame_r      <= tx_valid ? tx_frame : {NUM_BYTES{FILL_BYTE}};
                    underrun_r   <= !tx_valid;
                    miso_r       <= load_bit_s;
                    bit_count_r  <= 3'd0;
                    byte_count_r <= '0;
                    byte_sent_r  <= 1'b0;
                    busy_r       <= 1'b1;
                    state_r      <= SHIFT;
                end
                SHIFT: begin
                    bit_count_r  <= nxt_bit_s;
                    byte_count_r <= nxt_byte_s;
                    miso_r       <= shift_bit_s;
                    byte_sent_r  <= (nxt_bit_s == 3'd7);
                    busy_r       <= 1'b1;
                    if (last_edge_s) begin
                        frame_done_r <= 1'b1;
                        state_r      <= OVERFLOW;
                    end else begin
                        state_r      <= SHIFT;
                    end
                end
                OVERFLOW: begin
                    bit_count_r  <= nxt_bit_s;
                    byte_count_r <= BC_W'(NUM_BYTES);
                    miso_r       <= fill_bit_s;
                    byte_sent_r  <= (nxt_bit_s == 3'd7);
                    overrun_r    <= 1'b1;
                    busy_r       <= 1'b1;
                    state_r      <= OVERFLOW;
                end
                default: begin
                    state_r      <= IDLE;
                    miso_r       <= 1'b0;
                    bit_count_r  <= 3'd0;
                    byte_count_r <= '0;
                    byte_sent_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign miso_oe    = !ss && rst_n;
    assign miso       = miso_r;
    assign bit_count  = bit_count_r;
    assign byte_count = byte_count_r;
    assign byte_sent  = byte_sent_r;
    assign frame_done = frame_done_r;
    assign underrun   = underrun_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx with a two-byte frame.
module tb_spi_slave_tx;

    localparam int NB   = 2;
    localparam int BC_W = $clog2(NB) + 1;

    logic              rst_n;
    logic              sclk;
    logic              ss;
    logic [NB*8-1:0]   tx_frame;
    logic              tx_valid;
    logic              miso;
    logic              miso_oe;
    logic [2:0]        bit_count;
    logic [BC_W-1:0]   byte_count;
    logic              byte_sent;
    logic              frame_done;
    logic              underrun;
    logic              overrun;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic exp_under;
    logic [15:0] exp_bits;

    spi_slave_tx #(.NUM_BYTES(NB), .FILL_BYTE(8'hFF)) dut (
        .rst_n      (rst_n),
        .sclk       (sclk),
        .ss         (ss),
        .tx_frame   (tx_frame),
        .tx_valid   (tx_valid),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .bit_count  (bit_count),
        .byte_count (byte_count),
        .byte_sent  (byte_sent),
        .frame_done (frame_done),
        .underrun   (underrun),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One falling edge then a rising edge; outputs sampled mid low phase.
    task automatic fall_edge();
        sclk = 1'b0;
        #5;
    endtask

    task automatic rise_edge();
        sclk = 1'b1;
        #5;
    endtask

    // Edge k of a transaction; expected miso supplied by caller.
    task automatic edge_chk(input int k, input logic exp_miso);
        int exp_byte;
        fall_edge();
        exp_byte = (k > 8*NB) ? NB : (k - 1) / 8;
        chk($sformatf("miso_E%0d", k), 32'(miso), 32'(exp_miso));
        chk($sformatf("bitcnt_E%0d", k), 32'(bit_count), 32'((k - 1) % 8));
        chk($sformatf("bytecnt_E%0d", k), 32'(byte_count), 32'(exp_byte));
        chk($sformatf("bytesent_E%0d", k), 32'(byte_sent), 32'(k % 8 == 0));
        chk($sformatf("framedone_E%0d", k), 32'(frame_done), 32'(k >= 8*NB));
        chk($sformatf("overrun_E%0d", k), 32'(overrun), 32'(k > 8*NB));
        chk($sformatf("underrun_E%0d", k), 32'(underrun), 32'(exp_under));
        chk($sformatf("busy_E%0d", k), 32'(busy), 32'd1);
        rise_edge();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_miso"}, 32'(miso), 32'd0);
        chk({tag, "_bit"}, 32'(bit_count), 32'd0);
        chk({tag, "_byte"}, 32'(byte_count), 32'd0);
        chk({tag, "_flags"}, {28'd0, byte_sent, frame_done, underrun, overrun}, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_oe"}, 32'(miso_oe), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ss       = 1'b1;
        sclk     = 1'b1;
        tx_frame = 16'hA55A;
        tx_valid = 1'b1;
        exp_under = 1'b0;
        #10;
        chk_cleared("reset");
        rst_n = 1'b1;
        #10;
        chk("oe_ss_high", 32'(miso_oe), 32'd0);

        // Normal frame A55A: byte0 5A then byte1 A5; frame changed after E1.
        ss = 1'b0;
        #5;
        chk("oe_ss_low", 32'(miso_oe), 32'd1);
        exp_bits = 16'b0101_1010_1010_0101;
        edge_chk(1, exp_bits[15]);
        tx_frame = 16'h1234;
        tx_valid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            edge_chk(k, exp_bits[16 - k]);
        end
        // Past the end of the frame: fill byte and overrun.
        for (int k = 17; k <= 24; k++) begin
            edge_chk(k, 1'b1);
        end
        ss = 1'b1;
        #5;
        chk_cleared("ss_clear1");

        // Underrun: tx_valid low at capture, all ones.
        tx_frame = 16'hA55A;
        tx_valid = 1'b0;
        ss = 1'b0;
        #5;
        exp_under = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            edge_chk(k, 1'b1);
        end
        ss = 1'b1;
        #5;
        chk_cleared("ss_clear2");

        // ss raised mid-byte, then new transaction with 00C3.
        exp_under = 1'b0;
        tx_valid = 1'b1;
        tx_frame = 16'hA55A;
        ss = 1'b0;
        #5;
        for (int k = 1; k <= 5; k++) begin
            edge_chk(k, exp_bits[16 - k]);
        end
        ss = 1'b1;
        #5;
        chk_cleared("ss_midbyte");
        tx_frame = 16'h00C3;
        ss = 1'b0;
        #5;
        exp_bits = 16'b1100_0011_0000_0000;
        for (int k = 1; k <= 8; k++) begin
            edge_chk(k, exp_bits[16 - k]);
        end
        ss = 1'b1;
        #5;

        // Reset pulsed mid-frame with ss held low; next edge reloads.
        tx_frame = 16'hA55A;
        ss = 1'b0;
        #5;
        exp_bits = 16'b0101_1010_1010_0101;
        for (int k = 1; k <= 10; k++) begin
            edge_chk(k, exp_bits[16 - k]);
        end
        rst_n = 1'b0;
        #5;
        chk_cleared("rst_mid");
        rst_n = 1'b1;
        tx_frame = 16'h00C3;
        #5;
        chk("oe_after_rst", 32'(miso_oe), 32'd1);
        exp_bits = 16'b1100_0011_0000_0000;
        for (int k = 1; k <= 8; k++) begin
            edge_chk(k, exp_bits[16 - k]);
        end
        ss = 1'b1;
        #5;
        chk("oe_end", 32'(miso_oe), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_tx.md
Name: spi_slave_tx

Overview:
- SPI slave transmitter for the MISO direction, SPI mode 3 (CPOL=1, CPHA=1), MSB first within each byte.
- Captures a parallel frame of NUM_BYTES bytes at the start of a transaction, then shifts it out on MISO, one bit per sclk falling edge.
- Sits beside the existing MOSI slave receiver on the same sclk/ss pins; status outputs feed the same byte/frame bookkeeping logic.

Parameters:
- NUM_BYTES, 8, bytes per frame; legal range 1..16.
- FILL_BYTE, 8'hFF, byte driven on underrun and after the frame is exhausted.
- localparam BC_W = $clog2(NUM_BYTES)+1, width of byte_count.

Ports:
- rst_n  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock, idles high; all registers update on its falling edge (the mode-3 drive edge).
- ss  input  1  slave select, active-low; high acts as an additional asynchronous clear of the transaction state.
- tx_frame  input  NUM_BYTES*8  frame data; byte k = tx_frame[8k+7:8k]; byte 0 is sent first. Must be stable while ss is high.
- tx_valid  input  1  frame valid, sampled at the first falling edge of a transaction.
- miso  output  1  serial data, registered.
- miso_oe  output  1  pad output enable = !ss && rst_n (combinational).
- bit_count  output  3  index of the bit currently driven, 0..7 (0 = MSB).
- byte_count  output  BC_W  index of the byte currently driven.
- byte_sent  output  1  one-edge pulse: the LSB of a byte is being driven.
- frame_done  output  1  sticky: the last bit of the last byte has been driven.
- underrun  output  1  sticky: tx_valid was low at capture.
- overrun  output  1  sticky: master clocked past the end of the frame.
- busy  output  1  high in SHIFT or OVERFLOW.

Behaviour:
- Reset (rst_n low) or ss high asynchronously forces the following:
  - state=IDLE
  - miso=0, bit_count=0, byte_count=0
  - byte_sent=0, frame_done=0, underrun=0, overrun=0
  - the internal frame buffer is cleared.
- States: IDLE, SHIFT, OVERFLOW. State advances only on sclk falling edges with ss low.
- Falling edges of a transaction are numbered E1, E2, …
- IDLE at E1:
  - Load frame buffer = tx_valid ? tx_frame : {NUM_BYTES{FILL_BYTE}}.
  - underrun <= !tx_valid.
  - miso <= bit 7 of byte 0 (the value being loaded).
  - bit_count=0, byte_count=0; go to SHIFT.
- SHIFT at each edge Ek, k=2..8*NUM_BYTES:
  - If bit_count==7: bit_count<=0, byte_count++.
  - Otherwise: bit_count++.
  - miso <= buffer bit [byte_count'][7-bit_count'], using the new indices.
  - Zero latency: the bit appears at the falling edge and the master samples it on the following rising edge.
- byte_sent <= 1 on the edge where the new bit_count==7; 0 on every other edge.
- Frame end: at edge E(8*NUM_BYTES), frame_done <= 1 and the state moves to OVERFLOW on the next edge.
- OVERFLOW at each edge:
  - miso <= FILL_BYTE bits, MSB first, cycling with bit_count, which continues to wrap 0..7.
  - byte_count holds at NUM_BYTES.
  - overrun <= 1 from the first OVERFLOW edge.
  - byte_sent keeps pulsing every 8th edge.
- tx_frame and tx_valid changes after E1 have no effect until the next transaction.
- ss high mid-byte: immediate async clear; the next ss-low transaction restarts at byte 0, bit 7.
- Reset mid-frame: same as ss high; all sticky flags are cleared.
- Flags stay visible for the whole low period of ss and are observable until ss rises.

Test Plan:
- NUM_BYTES=2, tx_frame=16'hA55A, tx_valid=1, 16 edges → miso = 0,1,0,1,1,0,1,0, 1,0,1,0,0,1,0,1; byte_sent high at E8 and E16; frame_done=1 after E16; underrun=0, overrun=0.
- Same setup with tx_valid=0 at E1 → 16 ones on miso; underrun=1 after E1.
- NUM_BYTES=2, 20 edges → E17..E20 drive 1,1,1,1; overrun=1 from E17; byte_count stays 2.
- ss raised after E5, then a new transaction with 16'h00C3 → second transaction starts with 1,1,0,0,0,0,1,1 (byte 0x C3); bit_count/byte_count are 0 while ss is high.
- rst_n pulsed low after E10 while ss stays low → all outputs 0; the next falling edge acts as E1 and reloads tx_frame.
- tx_frame changed after E1 → shifted data still equals the frame captured at E1; miso_oe tracks !ss asynchronously.
